// File: rtl/sync_barrier_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_barrier_ctrl_if
// Purpose  : Barrier request, mask-table write and release/status bundle
//            between the proc cores and the sync barrier controller.
// Revision : 1.0
// ============================================================================
interface sync_barrier_ctrl_if #(
    parameter int N_CORES            = 4,
    parameter int SYNC_BARRIER_WIDTH = 8
);
    logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_barrier;
    logic [N_CORES-1:0]                    sync_barrier_en;
    logic [SYNC_BARRIER_WIDTH-1:0]         mask_write_addr;
    logic [N_CORES-1:0]                    mask_write;
    logic                                  mask_write_enable;
    logic [N_CORES-1:0]                    sync_enable;
    logic [N_CORES-1:0]                    waiting;
    logic                                  err_mask;
    logic                                  err_rearrive;
    logic [N_CORES-1:0]                    err_timeout;

    modport master (
        output sync_barrier, sync_barrier_en, mask_write_addr, mask_write, mask_write_enable,
        input  sync_enable, waiting, err_mask, err_rearrive, err_timeout
    );

    modport slave (
        input  sync_barrier, sync_barrier_en, mask_write_addr, mask_write, mask_write_enable,
        output sync_enable, waiting, err_mask, err_rearrive, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/sync_barrier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_barrier_ctrl
// Purpose  : Parks arriving cores per barrier id and releases all mask
//            participants together with a one-cycle sync_enable pulse.
// Revision : 1.0
// ============================================================================
module sync_barrier_ctrl #(
    parameter int N_CORES            = 4,
    parameter int SYNC_BARRIER_WIDTH = 8,
    parameter int TIMEOUT_WIDTH      = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    sync_barrier_ctrl_if.slave bus
);
    localparam int SBW   = SYNC_BARRIER_WIDTH;
    localparam int TW    = TIMEOUT_WIDTH;
    localparam int DEPTH = 1 << SBW;
    localparam logic [TW-1:0] C_CNT_MAX = '1;
    localparam logic [TW-1:0] C_CNT_ONE = TW'(1);
    localparam logic [TW-1:0] C_CNT_PRE = C_CNT_MAX - C_CNT_ONE;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state     [N_CORES];
    state_t             w_state_nxt [N_CORES];
    logic [SBW-1:0]     r_id        [N_CORES];
    logic [SBW-1:0]     w_id_nxt    [N_CORES];
    logic [SBW-1:0]     w_arr_id    [N_CORES];
    logic [TW-1:0]      r_cnt       [N_CORES];
    logic [TW-1:0]      w_cnt_nxt   [N_CORES];
    logic [N_CORES-1:0] w_hold_mask [N_CORES];
    logic [N_CORES-1:0] r_mem       [DEPTH];

    logic [N_CORES-1:0] w_rel;
    logic [N_CORES-1:0] r_sync_en;
    logic [N_CORES-1:0] w_waiting;
    logic [N_CORES-1:0] r_err_to;
    logic [N_CORES-1:0] w_err_to_nxt;
    logic               r_err_mask;
    logic               w_err_mask_nxt;
    logic               r_err_rearrive;
    logic               w_err_rearrive_nxt;

    // Table deliberately has no reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (bus.mask_write_enable) begin
            r_mem[bus.mask_write_addr] <= bus.mask_write;
        end
    end

    // A waiting core is released when every participant of its id is parked on that id.
    always_comb begin
        w_rel = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_hold_mask[i] = r_mem[r_id[i]];
            w_waiting[i]   = (r_state[i] == S_WAIT);
            w_rel[i]       = (r_state[i] == S_WAIT) && w_hold_mask[i][i];
            for (int j = 0; j < N_CORES; j++) begin
                if (w_hold_mask[i][j] && !((r_state[j] == S_WAIT) && (r_id[j] == r_id[i]))) begin
                    w_rel[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_err_mask_nxt     = r_err_mask;
        w_err_rearrive_nxt = r_err_rearrive;
        w_err_to_nxt       = r_err_to;
        for (int i = 0; i < N_CORES; i++) begin
            w_state_nxt[i] = r_state[i];
            w_id_nxt[i]    = r_id[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_arr_id[i]    = bus.sync_barrier[i*SBW +: SBW];
            if (r_state[i] == S_WAIT) begin
                if (bus.sync_barrier_en[i]) begin
                    w_err_rearrive_nxt = 1'b1;
                end
                if (w_rel[i]) begin
                    w_state_nxt[i] = S_IDLE;
                    w_cnt_nxt[i]   = '0;
                end else if (r_cnt[i] != C_CNT_MAX) begin
                    w_cnt_nxt[i] = r_cnt[i] + C_CNT_ONE;
                    // Flag lands together with the counter reaching all-ones.
                    if (r_cnt[i] == C_CNT_PRE) begin
                        w_err_to_nxt[i] = 1'b1;
                    end
                end
            end else if (bus.sync_barrier_en[i]) begin
                if (r_mem[w_arr_id[i]][i]) begin
                    w_state_nxt[i] = S_WAIT;
                    w_id_nxt[i]    = w_arr_id[i];
                    w_cnt_nxt[i]   = '0;
                end else begin
                    w_err_mask_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CORES; i++) begin
                r_state[i] <= S_IDLE;
                r_id[i]    <= '0;
                r_cnt[i]   <= '0;
            end
            r_sync_en      <= '0;
            r_err_to       <= '0;
            r_err_mask     <= 1'b0;
            r_err_rearrive <= 1'b0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_id[i]    <= w_id_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_sync_en      <= w_rel;
            r_err_to       <= w_err_to_nxt;
            r_err_mask     <= w_err_mask_nxt;
            r_err_rearrive <= w_err_rearrive_nxt;
        end
    end

    assign bus.sync_enable  = r_sync_en;
    assign bus.waiting      = w_waiting;
    assign bus.err_mask     = r_err_mask;
    assign bus.err_rearrive = r_err_rearrive;
    assign bus.err_timeout  = r_err_to;

endmodule
`default_nettype wire

// File: tb/tb_sync_barrier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_barrier_ctrl
// Purpose  : Scoreboard bench; an arrival-list reference model predicts
//            releases and status, a negedge monitor checks the DUT.
// Revision : 1.0
// ============================================================================
module tb_sync_barrier_ctrl;
    localparam int N     = 4;
    localparam int SBW   = 3;
    localparam int TW    = 4;
    localparam int DEPTH = 1 << SBW;
    localparam int CNT_MAX = (1 << TW) - 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] vec;
    } rel_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] wt;
        logic         em;
        logic         er;
        logic [N-1:0] eto;
    } st_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;

    rel_t q_rel[$];
    st_t  q_st[$];

    // Reference model: which id each core is parked on (-1 = free) and since when.
    logic [N-1:0] m_mem [DEPTH];
    int           m_id    [N];
    int           m_since [N];
    logic         m_errm;
    logic         m_errr;
    logic [N-1:0] m_errto;

    sync_barrier_ctrl_if #(.N_CORES(N), .SYNC_BARRIER_WIDTH(SBW)) bif ();

    sync_barrier_ctrl #(
        .N_CORES            (N),
        .SYNC_BARRIER_WIDTH (SBW),
        .TIMEOUT_WIDTH      (TW)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc    = 0;
        m_errm = 1'b0;
        m_errr = 1'b0;
        m_errto = '0;
        for (int i = 0; i < N; i++) begin
            m_id[i]    = -1;
            m_since[i] = 0;
        end
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    end

    always @(posedge clk) begin
        logic [N-1:0] rel;
        logic [N-1:0] wt;
        logic         all_in;
        int           d;
        int           aid;
        st_t          s;
        rel_t         r;
        rel = '0;
        for (int j = 0; j < N; j++) begin
            if (m_id[j] >= 0 && m_mem[m_id[j]][j]) begin
                d = m_id[j];
                all_in = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (m_mem[d][k] && m_id[k] != d) all_in = 1'b0;
                end
                rel[j] = all_in;
            end
        end
        if (rst) begin
            rel = '0;
            for (int i = 0; i < N; i++) m_id[i] = -1;
            m_errm = 1'b0;
            m_errr = 1'b0;
            m_errto = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_id[i] >= 0) begin
                    if (bif.sync_barrier_en[i]) m_errr = 1'b1;
                    if (rel[i]) m_id[i] = -1;
                    else if (cyc + 1 - m_since[i] >= CNT_MAX) m_errto[i] = 1'b1;
                end else if (bif.sync_barrier_en[i]) begin
                    aid = int'(bif.sync_barrier[i*SBW +: SBW]);
                    if (m_mem[aid][i]) begin
                        m_id[i]    = aid;
                        m_since[i] = cyc + 1;
                    end else begin
                        m_errm = 1'b1;
                    end
                end
            end
        end
        if (bif.mask_write_enable) m_mem[bif.mask_write_addr] = bif.mask_write;
        for (int i = 0; i < N; i++) wt[i] = (m_id[i] >= 0);
        s.cyc = cyc + 1;
        s.wt  = wt;
        s.em  = m_errm;
        s.er  = m_errr;
        s.eto = m_errto;
        q_st.push_back(s);
        if (rel != '0) begin
            r.cyc = cyc + 1;
            r.vec = rel;
            q_rel.push_back(r);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        st_t  s;
        rel_t r;
        if (bif.sync_enable != '0) begin
            vectors++;
            if (q_rel.size() == 0) begin
                miscompares++;
                $display("FAIL release cyc=%0d: got sync_enable=%b, expected none", cyc, bif.sync_enable);
            end else begin
                r = q_rel.pop_front();
                if (r.cyc != cyc || r.vec != bif.sync_enable) begin
                    miscompares++;
                    $display("FAIL release cyc=%0d: got sync_enable=%b, expected %b at cyc %0d",
                             cyc, bif.sync_enable, r.vec, r.cyc);
                end
            end
        end else if (q_rel.size() > 0 && q_rel[0].cyc <= cyc) begin
            vectors++;
            miscompares++;
            r = q_rel.pop_front();
            $display("FAIL missed_release cyc=%0d: got sync_enable=0, expected %b", cyc, r.vec);
        end
        if (q_st.size() > 0) begin
            s = q_st.pop_front();
            vectors++;
            if (s.wt !== bif.waiting || s.em !== bif.err_mask || s.er !== bif.err_rearrive
                || s.eto !== bif.err_timeout) begin
                miscompares++;
                $display("FAIL status cyc=%0d: got wait=%b em=%b er=%b eto=%b, expected wait=%b em=%b er=%b eto=%b",
                         cyc, bif.waiting, bif.err_mask, bif.err_rearrive, bif.err_timeout,
                         s.wt, s.em, s.er, s.eto);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mask(input int addr, input logic [N-1:0] m);
        bif.mask_write_enable = 1'b1;
        bif.mask_write_addr   = SBW'(addr);
        bif.mask_write        = m;
        step(1);
        bif.mask_write_enable = 1'b0;
    endtask

    task automatic arrive(input logic [N-1:0] cores, input int id);
        for (int c = 0; c < N; c++) begin
            if (cores[c]) bif.sync_barrier[c*SBW +: SBW] = SBW'(id);
        end
        bif.sync_barrier_en = cores;
        step(1);
        bif.sync_barrier_en = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bif.sync_barrier      = '0;
        bif.sync_barrier_en   = '0;
        bif.mask_write_addr   = '0;
        bif.mask_write        = '0;
        bif.mask_write_enable = 1'b0;
        for (int a = 0; a < DEPTH; a++) set_mask(a, '1);
        step(1);
        rst = 1'b0;
        step(2);

        // Staggered arrivals on a four-way barrier.
        set_mask(5, 4'b1111);
        for (int t = 0; t <= 10; t++) begin
            if (t == 0)       arrive(4'b0001, 5);
            else if (t == 2)  arrive(4'b0010, 5);
            else if (t == 5)  arrive(4'b0100, 5);
            else if (t == 10) arrive(4'b1000, 5);
            else              step(1);
        end
        step(4);

        // Two disjoint barriers arriving in the same cycle.
        set_mask(3, 4'b0011);
        set_mask(7, 4'b1100);
        bif.sync_barrier = {3'd7, 3'd7, 3'd3, 3'd3};
        bif.sync_barrier_en = 4'b1111;
        step(1);
        bif.sync_barrier_en = '0;
        step(4);

        // Non-participant arrival, then the real participants.
        set_mask(2, 4'b0101);
        arrive(4'b0010, 2);
        step(3);
        arrive(4'b0001, 2);
        step(2);
        arrive(4'b0100, 2);
        step(4);

        // Re-arrival while parked.
        set_mask(5, 4'b0011);
        arrive(4'b0001, 5);
        arrive(4'b0001, 5);
        step(1);
        arrive(4'b0001, 5);
        arrive(4'b0010, 5);
        step(4);

        // Randomised traffic with occasional table writes and resets.
        for (int t = 0; t < 600; t++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst = (r < 3);
            if (r >= 3 && r < 10) begin
                bif.mask_write_enable = 1'b1;
                bif.mask_write_addr   = SBW'($urandom_range(0, DEPTH - 1));
                bif.mask_write        = N'($urandom_range(1, (1 << N) - 1));
            end
            for (int c = 0; c < N; c++) begin
                bif.sync_barrier_en[c] = ($urandom_range(0, 99) < 15);
                bif.sync_barrier[c*SBW +: SBW] = SBW'($urandom_range(0, 3));
            end
            step(1);
            bif.sync_barrier_en   = '0;
            bif.mask_write_enable = 1'b0;
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // Lone participant times out; reset abandons the wait; table survives.
        set_mask(1, 4'b0011);
        arrive(4'b0001, 1);
        step(20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);
        arrive(4'b0011, 1);
        step(6);

        vectors++;
        if (q_rel.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending releases, expected 0", q_rel.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sync_barrier_ctrl.md
Name: sync_barrier_ctrl

Overview:
- Multi-core synchronisation controller for the N-core simulation/system toplevel; generalises the single-core case, where `sync_enable` is tied externally.
- Collects `sync_barrier_en_out` / `sync_barrier` requests from N proc cores.
- Looks up each barrier's participant mask in a writable table.
- Releases every participant with a one-cycle `sync_enable` pulse once all of them have arrived at the same barrier id.
- Flags protocol errors and per-core wait timeouts.

Parameters:
N_CORES, 4, number of proc cores served (1..16)
SYNC_BARRIER_WIDTH, 8, barrier id width; mask table depth = 2**SYNC_BARRIER_WIDTH
TIMEOUT_WIDTH, 16, width of per-core wait counter; timeout at all-ones

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sync_barrier  input  N_CORES*SYNC_BARRIER_WIDTH  per-core barrier id, core i at [i*SBW +: SBW]
sync_barrier_en  input  N_CORES  per-core arrival pulse (from proc sync_barrier_en_out)
mask_write_addr  input  SYNC_BARRIER_WIDTH  mask table write address
mask_write  input  N_CORES  participant mask to write
mask_write_enable  input  1  mask table write strobe
sync_enable  output  N_CORES  per-core release pulse (to proc sync_enable)
waiting  output  N_CORES  core currently parked at a barrier
err_mask  output  1  sticky: arriving core not in its barrier's mask
err_rearrive  output  1  sticky: arrival pulse while core already waiting
err_timeout  output  N_CORES  sticky per core: wait counter saturated

Behaviour:
- Reset:
  - all outputs 0; all per-core state IDLE; wait counters 0.
  - Mask table is NOT cleared by reset; it keeps its contents and is unknown after power-up until written.
- Mask table:
  - Synchronous write: `mask_write` lands at `mask_write_addr` when `mask_write_enable` is high.
  - Read is combinational, per core, indexed by that core's latched id.
  - A write to an id with cores already waiting takes effect in the same cycle's release evaluation (the new mask is used from the cycle after the write edge).
- Per-core state: IDLE or WAIT(id).
- Arrival, core i in IDLE with `sync_barrier_en[i]`=1:
  - Latch id and go to WAIT(id); `waiting[i]`=1 from the next cycle.
  - If mask(id)[i]=0: set `err_mask`, stay IDLE, no release.
- Release condition, evaluated each cycle for each id held by a waiting core: every core j with mask(id)[j]=1 is in WAIT(id).
  - Release is registered: for each such j, `sync_enable[j]`=1 for exactly one cycle.
  - In that same cycle each such j returns to IDLE, `waiting[j]` drops, and its counter clears.
  - Minimum latency: last arrival pulse at cycle T -> `waiting` rises at T+1 -> `sync_enable` high at T+2.
  - A single-participant mask releases at T+2.
- Simultaneous arrivals:
  - Cores pulsing in the same cycle are handled independently.
  - Different ids evaluate independently; disjoint barriers may release in the same cycle.
- Re-arrival:
  - A pulse on a core in WAIT sets `err_rearrive` and is ignored; id and counter are unchanged.
  - A pulse in the release cycle itself (core going IDLE) is also ignored and flagged.
- Mismatched ids: a core waiting on id A never satisfies id B's condition; no error, other cores simply stall.
- Timeout:
  - The counter increments each WAIT cycle and saturates at 2**TIMEOUT_WIDTH-1.
  - At saturation, `err_timeout[i]` sets (sticky); the core keeps waiting, with no forced release.
- Error flags clear only on reset.
- Reset mid-wait: all waits abandoned; no `sync_enable` pulse is emitted in or after the reset cycle.
- Arithmetic: masks are N_CORES bits; the id index is unsigned; no wrap on counters (they saturate).

Test Plan:
- Mask[5]=4'b1111; cores 0..3 pulse id 5 at cycles 10, 12, 15, 20 -> `sync_enable`=4'b1111 only at cycle 22; `waiting` 0 afterwards.
- Mask[3]=4'b0011, mask[7]=4'b1100; all four cores pulse the same cycle (0,1 on id 3; 2,3 on id 7) -> both pairs released together two cycles later; no errors.
- Mask[2]=4'b0101; core 1 pulses id 2 -> `err_mask`=1, `waiting[1]`=0, no release; cores 0 and 2 later pulse id 2 -> released normally.
- Core 0 pulses id 5 twice while waiting (mask 4'b0011) -> `err_rearrive`=1; core 1 arrives -> single release pulse on cores 0,1.
- TIMEOUT_WIDTH=4, mask[1]=4'b0011, only core 0 arrives -> `err_timeout[0]` sets 15 cycles after `waiting[0]` rises; reset asserted mid-wait -> all outputs 0 next cycle; mask[1] still 4'b0011 after reset.
